fixed_dot_accum: RTL and testbench

- Streaming fixed-point dot-product accumulator for the gradient-descent datapath.
- Accepts pairs of Q8.8 operands over a valid/ready handshake and multiplies each pair.
- Rescales each product to Q.8 and accumulates into a 64-bit Q56.8 sum.
- Sits directly upstream of the Q56.8 to Q8.8 saturating clamp: sum_out feeds the clamp's 64-bit input unmodified. No saturation is applied here.

---
 rtl/fixed_dot_accum_if.sv | 28 ++
 rtl/fixed_dot_accum.sv | 131 +++++++++++++
 tb/tb_fixed_dot_accum.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fixed_dot_accum_if.sv
// Operand/result handshake bundle for the fixed-point dot-product accumulator.
// The master drives operands and the result-accept strobe; the slave returns the result.
interface fixed_dot_accum_if #(
    parameter int CW = 9
);
    logic           start;
    logic [15:0]    a_in;
    logic [15:0]    b_in;
    logic           in_valid;
    logic           in_last;
    logic           in_ready;
    logic [63:0]    sum_out;
    logic [CW-1:0]  count_out;
    logic           out_valid;
    logic           out_ready;
    logic           len_err;
    logic           busy;

    modport master (
        output start, a_in, b_in, in_valid, in_last, out_ready,
        input  in_ready, sum_out, count_out, out_valid, len_err, busy
    );

    modport slave (
        input  start, a_in, b_in, in_valid, in_last, out_ready,
        output in_ready, sum_out, count_out, out_valid, len_err, busy
    );
endinterface

// File: rtl/fixed_dot_accum.sv
// Streaming Q8.8 x Q8.8 dot product accumulated into a wrapping Q56.8 sum.
// Two-stage datapath: registered Q16.16 product, then rescale-and-accumulate.
module fixed_dot_accum #(
    parameter int MAX_LEN    = 256,
    parameter int ROUND_MODE = 0,
    parameter int CW         = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    fixed_dot_accum_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic signed [31:0] BIAS = (ROUND_MODE != 0) ? 32'sd128 : 32'sd0;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_busy;
    logic               r_out_valid;
    logic               r_len_err;
    logic [CW-1:0]      r_count;
    logic [CW-1:0]      r_count_out;
    logic [63:0]        r_sum_out;
    logic signed [31:0] r_prod;
    logic               r_s1_valid;
    logic signed [63:0] r_acc;

    logic               w_xfer;
    logic               w_final;
    logic [CW-1:0]      w_count_next;
    logic signed [31:0] w_prod;
    logic signed [31:0] w_biased;
    logic signed [63:0] w_scaled;

    assign w_xfer       = r_in_ready & bus.in_valid;
    assign w_count_next = r_count + CW'(1);
    assign w_final      = bus.in_last | (w_count_next == CW'(MAX_LEN));

    assign w_prod   = $signed(bus.a_in) * $signed(bus.b_in);
    assign w_biased = r_prod + BIAS;
    // Arithmetic shift by 8 taken as a bit slice, then sign-extended to 64 bits
    assign w_scaled = {{40{w_biased[31]}}, w_biased[31:8]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod     <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_prod <= w_prod;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_acc <= '0;
        end else if (r_s1_valid) begin
            r_acc <= r_acc + w_scaled;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_len_err   <= 1'b0;
            r_count     <= '0;
            r_count_out <= '0;
            r_sum_out   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_count    <= '0;
                        r_len_err  <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_xfer) begin
                        r_count <= w_count_next;
                        if (w_final) begin
                            r_in_ready <= 1'b0;
                            r_len_err  <= ~bus.in_last;
                            r_state    <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Stage 1 empties one cycle after the final transfer; the sum is then complete
                    if (!r_s1_valid) begin
                        r_sum_out   <= r_acc;
                        r_count_out <= r_count;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.busy      = r_busy;
    assign bus.out_valid = r_out_valid;
    assign bus.len_err   = r_len_err;
    assign bus.sum_out   = r_sum_out;
    assign bus.count_out = r_count_out;
endmodule

// File: tb/tb_fixed_dot_accum.sv
// Drives three accumulator configurations (floor, round-half-up, MAX_LEN=4) with one
// shared directed stimulus and checks each against a transaction-level model every cycle.
`timescale 1ns/1ps
module tb_fixed_dot_accum;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic [15:0] a_in;
    logic [15:0] b_in;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0]  w_ov;
    logic [2:0]  w_busy;
    logic [2:0]  w_rdy;
    logic [2:0]  w_lerr;
    logic [63:0] w_sum [3];
    logic [8:0]  w_cnt [3];

    always #5 clk = ~clk;

    function automatic int cfg_ml(input int i);
        return (i == 2) ? 4 : 256;
    endfunction

    function automatic int cfg_rm(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    // Q16.16 product to Q.8: floor division by 256, optionally biased by half an output LSB
    function automatic longint rescale(input longint a, input longint b, input int rm);
        longint p;
        p = a * b;
        if (rm != 0) p = p + 128;
        return p >>> 8;
    endfunction

    function automatic longint dot(input longint qa[$], input longint qb[$], input int rm);
        longint s;
        s = 0;
        foreach (qa[i]) s = s + rescale(qa[i], qb[i], rm);
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            localparam int P_ML = cfg_ml(gi);
            localparam int P_RM = cfg_rm(gi);
            localparam int P_CW = $clog2(P_ML + 1);

            fixed_dot_accum_if #(.CW(P_CW)) bus ();

            assign bus.start     = start;
            assign bus.a_in      = a_in;
            assign bus.b_in      = b_in;
            assign bus.in_valid  = in_valid;
            assign bus.in_last   = in_last;
            assign bus.out_ready = out_ready;

            fixed_dot_accum #(
                .MAX_LEN    (P_ML),
                .ROUND_MODE (P_RM),
                .CW         (P_CW)
            ) u_dut (
                .clk (clk),
                .rst (rst),
                .bus (bus)
            );

            assign w_ov[gi]   = bus.out_valid;
            assign w_busy[gi] = bus.busy;
            assign w_rdy[gi]  = bus.in_ready;
            assign w_lerr[gi] = bus.len_err;
            assign w_sum[gi]  = bus.sum_out;
            assign w_cnt[gi]  = 9'(bus.count_out);

            // Model: collect accepted pairs; result appears two edges after the closing transfer
            longint qa[$];
            longint qb[$];
            bit     m_on;
            bit     m_hold;
            bit     m_lerr_n;
            bit     m_exp_lerr;
            int     m_pend;
            int     m_exp_cnt;
            longint m_exp_sum;

            always @(posedge clk or posedge rst) begin
                if (rst) begin
                    m_on = 0; m_hold = 0; m_pend = 0; m_lerr_n = 0;
                    qa.delete(); qb.delete();
                    m_exp_sum = 0; m_exp_cnt = 0; m_exp_lerr = 0;
                end else if (m_hold) begin
                    if (out_ready) m_hold = 0;
                end else if (m_pend > 0) begin
                    m_pend = m_pend - 1;
                    if (m_pend == 0) begin
                        m_hold     = 1;
                        m_exp_sum  = dot(qa, qb, P_RM);
                        m_exp_cnt  = qa.size();
                        m_exp_lerr = m_lerr_n;
                    end
                end else if (m_on) begin
                    if (in_valid) begin
                        qa.push_back(longint'($signed(a_in)));
                        qb.push_back(longint'($signed(b_in)));
                        if (in_last || qa.size() == P_ML) begin
                            m_on     = 0;
                            m_pend   = 2;
                            m_lerr_n = !in_last;
                        end
                    end
                end else if (start) begin
                    m_on = 1;
                    qa.delete(); qb.delete();
                end
            end

            always @(negedge clk) begin
                string nm;
                bit    idle_m;
                nm     = $sformatf("d%0d", gi);
                idle_m = !m_on && (m_pend == 0) && !m_hold;
                chk({nm, " in_ready"}, 64'(bus.in_ready), 64'(m_on));
                chk({nm, " busy"}, 64'(bus.busy), 64'(!idle_m));
                chk({nm, " out_valid"}, 64'(bus.out_valid), 64'(m_hold));
                if (m_hold || idle_m) begin
                    chk({nm, " sum_out"}, bus.sum_out, m_exp_sum);
                    chk({nm, " count_out"}, 64'(bus.count_out), 64'(m_exp_cnt));
                end
                if (m_hold || rst) begin
                    chk({nm, " len_err"}, 64'(bus.len_err), 64'(m_exp_lerr));
                end
            end
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
        a_in = a; b_in = b; in_valid = 1'b1; in_last = last;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_ov(input string tag);
        int n;
        n = 0;
        while (w_ov != 3'b111 && n < 50) begin
            tick();
            n++;
        end
        chk({tag, " out_valid wait"}, 64'(w_ov), 64'(3'b111));
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " back to idle"}, 64'(w_busy), 64'(3'b000));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b0; a_in = '0; b_in = '0;

        // Pin the model's rescale rule to hand-computed values
        chk("pin floor 0x80", rescale(1, 128, 0), 64'd0);
        chk("pin round 0x80", rescale(1, 128, 1), 64'd1);
        chk("pin floor -1", rescale(-1, 1, 0), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("pin extreme", rescale(-32768, -32768, 0), 64'h0000_0000_0040_0000);

        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        tick();
        chk("reset out_valid", 64'(w_ov), 64'd0);
        chk("reset in_ready", 64'(w_rdy), 64'd0);
        chk("reset busy", 64'(w_busy), 64'd0);
        chk("reset sum_out", w_sum[0], 64'd0);

        // Single element 1.5 * 2.0, with latency check
        do_start();
        send(16'h0180, 16'h0200, 1'b1);
        chk("t1 ov after E0", 64'(w_ov), 64'd0);
        tick();
        chk("t1 ov after E1", 64'(w_ov), 64'd0);
        tick();
        chk("t1 ov after E2", 64'(w_ov), 64'(3'b111));
        chk("t1 sum", w_sum[0], 64'h0000_0000_0000_0300);
        chk("t1 count", 64'(w_cnt[0]), 64'd1);
        chk("t1 len_err", 64'(w_lerr), 64'd0);
        release_result("t1");

        // Three elements, back to back: 1 - 6 + 0.25 = -4.75
        do_start();
        send(16'h0100, 16'h0100, 1'b0);
        send(16'hFE00, 16'h0300, 1'b0);
        send(16'h0080, 16'h0080, 1'b1);
        wait_ov("t2");
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t2 sum d%0d", k), w_sum[k], 64'hFFFF_FFFF_FFFF_FB40);
            chk($sformatf("t2 count d%0d", k), 64'(w_cnt[k]), 64'd3);
        end
        release_result("t2");

        // Gaps between elements, then a held result with start pulses that must be ignored
        do_start();
        send(16'h0200, 16'h0100, 1'b0);
        tick();
        send(16'h0100, 16'hFF00, 1'b0);
        tick();
        send(16'h0300, 16'h0100, 1'b1);
        wait_ov("t3");
        for (int k = 0; k < 5; k++) begin
            start = k[0];
            tick();
        end
        start = 1'b0;
        chk("t3 held ov", 64'(w_ov), 64'(3'b111));
        chk("t3 held sum", w_sum[0], 64'h0000_0000_0000_0400);
        chk("t3 held count", 64'(w_cnt[0]), 64'd3);
        chk("t3 held in_ready", 64'(w_rdy), 64'd0);
        release_result("t3");

        // Sub-LSB products: half-LSB, and -1/256 (the half-LSB bias lifts it to zero)
        do_start();
        send(16'h0001, 16'h0080, 1'b1);
        wait_ov("t4a");
        chk("t4a floor", w_sum[0], 64'd0);
        chk("t4a round", w_sum[1], 64'd1);
        release_result("t4a");
        do_start();
        send(16'hFFFF, 16'h0001, 1'b1);
        wait_ov("t4b");
        chk("t4b floor", w_sum[0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t4b round", w_sum[1], 64'd0);
        chk("t4b len4 floor", w_sum[2], 64'hFFFF_FFFF_FFFF_FFFF);
        release_result("t4b");

        // Length limit on the MAX_LEN=4 instance; the others close on a sixth, last pair
        do_start();
        for (int k = 0; k < 4; k++) send(16'h8000, 16'h8000, 1'b0);
        chk("t5 in_ready drop", 64'(w_rdy), 64'(3'b011));
        send(16'h8000, 16'h8000, 1'b0);
        send(16'h0100, 16'h0100, 1'b1);
        wait_ov("t5");
        chk("t5 len sum", w_sum[2], 64'h0000_0000_0100_0000);
        chk("t5 len count", 64'(w_cnt[2]), 64'd4);
        chk("t5 len_err", 64'(w_lerr), 64'(3'b100));
        chk("t5 clamp overflow", 64'($signed(w_sum[2]) > 64'sh7FFF), 64'd1);
        chk("t5 full sum", w_sum[0], 64'h0000_0000_0140_0100);
        chk("t5 full count", 64'(w_cnt[0]), 64'd6);
        release_result("t5");

        // Asynchronous reset mid-vector, then a clean vector with no residue
        do_start();
        send(16'h0100, 16'h0100, 1'b0);
        send(16'h0200, 16'h0200, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("t6 rst out_valid", 64'(w_ov), 64'd0);
        chk("t6 rst in_ready", 64'(w_rdy), 64'd0);
        chk("t6 rst busy", 64'(w_busy), 64'd0);
        chk("t6 rst len_err", 64'(w_lerr), 64'd0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t6 rst sum d%0d", k), w_sum[k], 64'd0);
            chk($sformatf("t6 rst count d%0d", k), 64'(w_cnt[k]), 64'd0);
        end
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        tick();
        do_start();
        send(16'h0100, 16'h0100, 1'b1);
        wait_ov("t6");
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t6 sum d%0d", k), w_sum[k], 64'h0000_0000_0000_0100);
            chk($sformatf("t6 count d%0d", k), 64'(w_cnt[k]), 64'd1);
        end
        release_result("t6");

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
